// File: rtl/store_narrow_serializer_if.sv
// Store request / memory write-beat bundle for store_narrow_serializer.
// The slave modport is the serializer; the master modport is its environment.
interface store_narrow_serializer_if #(
    parameter int DATA_WIDTH = 64,
    parameter int BUS_WIDTH  = 16
);
    logic                   in_valid;
    logic                   in_ready;
    logic [DATA_WIDTH-1:0]  in_data;
    logic [1:0]             in_size;
    logic                   in_signed;
    logic                   out_valid;
    logic                   out_ready;
    logic [BUS_WIDTH-1:0]   out_data;
    logic [BUS_WIDTH/8-1:0] out_be;
    logic                   out_last;
    logic                   out_ovf;

    modport master (
        output in_valid, in_data, in_size, in_signed, out_ready,
        input  in_ready, out_valid, out_data, out_be, out_last, out_ovf
    );

    modport slave (
        input  in_valid, in_data, in_size, in_signed, out_ready,
        output in_ready, out_valid, out_data, out_be, out_last, out_ovf
    );
endinterface

// File: rtl/store_narrow_serializer.sv
// Truncates a register value to the store size, flags lossy truncation,
// and streams the result little-endian over a narrower write bus.
module store_narrow_serializer #(
    parameter int DATA_WIDTH = 64,
    parameter int BUS_WIDTH  = 16
) (
    input logic                     clk,
    input logic                     reset,
    store_narrow_serializer_if.slave bus
);
    localparam int BEW = BUS_WIDTH / 8;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] data_q;
    logic [3:0]            cnt_q;
    logic [BEW-1:0]        be_q;
    logic                  valid_q;
    logic                  last_q;
    logic                  ovf_q;

    logic [6:0]            nbits;
    logic [3:0]            nbytes;
    logic [DATA_WIDTH-1:0] mask;
    logic [DATA_WIDTH-1:0] trunc;
    logic [DATA_WIDTH-1:0] sext;
    logic                  sign;
    logic                  ovf_c;
    logic [3:0]            beats_c;
    logic [BEW-1:0]        be_c;

    // Size decode, truncation and overflow of the request on the input side.
    always_comb begin
        nbits   = 7'd8 << bus.in_size;
        nbytes  = 4'd1 << bus.in_size;
        mask    = (64'd1 << nbits) - 64'd1;
        if (bus.in_size == 2'b11)
            mask = '1;
        trunc   = bus.in_data & mask;
        sign    = |(bus.in_data & (mask ^ (mask >> 1)));
        sext    = trunc | (sign ? ~mask : '0);
        ovf_c   = bus.in_signed ? (bus.in_data != sext)
                                : ((bus.in_data & ~mask) != '0);
        beats_c = 4'd1;
        if (nbytes > 4'(BEW))
            beats_c = nbytes / 4'(BEW);
        be_c = '1;
        if (int'(nbits) < BUS_WIDTH)
            be_c = BEW'((16'd1 << nbytes) - 16'd1);
    end

    // Accept one request in IDLE, then walk its beats out in SEND.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            be_q    <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        data_q  <= trunc;
                        cnt_q   <= beats_c;
                        be_q    <= be_c;
                        ovf_q   <= ovf_c;
                        valid_q <= 1'b1;
                        last_q  <= (beats_c == 4'd1);
                        state   <= SEND;
                    end
                end
                SEND: begin
                    if (bus.out_ready) begin
                        if (last_q) begin
                            data_q  <= '0;
                            cnt_q   <= '0;
                            be_q    <= '0;
                            ovf_q   <= 1'b0;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            data_q <= data_q >> BUS_WIDTH;
                            cnt_q  <= cnt_q - 4'd1;
                            last_q <= (cnt_q == 4'd2);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE) && !reset;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q[BUS_WIDTH-1:0];
    assign bus.out_be    = be_q;
    assign bus.out_last  = last_q;
    assign bus.out_ovf   = ovf_q;
endmodule

// File: tb/tb_store_narrow_serializer.sv
// Scoreboard bench for store_narrow_serializer with a 16-bit write bus.
// Expected beats are queued at request time and popped as beats are accepted.
module tb_store_narrow_serializer;
    logic clk;
    logic reset;
    int   n_chk;
    int   n_err;
    bit   rand_bp;

    typedef struct {
        logic [15:0] d;
        logic [1:0]  be;
        logic        last;
        logic        ovf;
    } beat_t;

    beat_t sb[$];

    store_narrow_serializer_if #(.DATA_WIDTH(64), .BUS_WIDTH(16)) bus ();

    store_narrow_serializer #(.DATA_WIDTH(64), .BUS_WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: truncate, overflow and split into 16-bit beats.
    task automatic model(input logic [63:0] d, input logic [1:0] sz,
                         input logic sg);
        int          n;
        int          nb;
        logic [63:0] tr;
        logic [63:0] sx;
        logic        ov;
        beat_t       b;
        n = 8 << sz;
        if (n == 64) begin
            tr = d;
            ov = 1'b0;
        end else begin
            tr = d & ((64'd1 << n) - 64'd1);
            sx = 64'($signed(tr << (64 - n)) >>> (64 - n));
            ov = sg ? (sx != d) : ((d >> n) != 64'd0);
        end
        nb = (n / 16 > 0) ? n / 16 : 1;
        for (int i = 0; i < nb; i++) begin
            b.d    = 16'(tr >> (16 * i));
            b.be   = (n < 16) ? 2'b01 : 2'b11;
            b.last = (i == nb - 1);
            b.ovf  = ov;
            sb.push_back(b);
        end
    endtask

    task automatic send(input logic [63:0] d, input logic [1:0] sz,
                        input logic sg);
        int k;
        k = 0;
        @(negedge clk);
        while (!bus.in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("in_ready_wait", 64'(bus.in_ready), 64'd1);
        model(d, sz, sg);
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_size   = sz;
        bus.in_signed = sg;
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.in_data   = {$urandom, $urandom};
        bus.in_size   = 2'($urandom);
        bus.in_signed = 1'($urandom);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("drain", 64'(sb.size()), 64'd0);
    endtask

    // Compare each accepted beat against the head of the scoreboard.
    always @(negedge clk) begin
        beat_t e;
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", 64'(bus.out_data), 64'hDEAD);
            end else begin
                e = sb.pop_front();
                chk("out_data", 64'(bus.out_data), 64'(e.d));
                chk("out_be", 64'(bus.out_be), 64'(e.be));
                chk("out_last", 64'(bus.out_last), 64'(e.last));
                chk("out_ovf", 64'(bus.out_ovf), 64'(e.ovf));
            end
        end
    end

    // Optional random backpressure on the write bus.
    always @(posedge clk) begin
        if (rand_bp) begin
            #1;
            bus.out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        n_chk         = 0;
        n_err         = 0;
        rand_bp       = 1'b0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_size   = 2'b00;
        bus.in_signed = 1'b0;
        bus.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data", 64'(bus.out_data), 64'd0);
        chk("rst_out_be", 64'(bus.out_be), 64'd0);
        chk("rst_out_last", 64'(bus.out_last), 64'd0);
        chk("rst_out_ovf", 64'(bus.out_ovf), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", 64'(bus.in_ready), 64'd1);

        // Signed byte without overflow; beat visible the cycle after accept.
        send(64'hFFFF_FFFF_FFFF_FF80, 2'b00, 1'b1);
        @(negedge clk);
        chk("latency_valid", 64'(bus.out_valid), 64'd1);
        chk("latency_in_ready", 64'(bus.in_ready), 64'd0);
        drain();

        send(64'h80, 2'b00, 1'b1);
        send(64'h80, 2'b00, 1'b0);
        drain();

        // Dword, full rate: four beats then in_ready on the following cycle.
        send(64'h0123_4567_89AB_CDEF, 2'b11, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("dw_valid", 64'(bus.out_valid), 64'd1);
            chk("dw_in_ready", 64'(bus.in_ready), 64'd0);
        end
        @(negedge clk);
        chk("dw_in_ready_after", 64'(bus.in_ready), 64'd1);
        chk("dw_valid_after", 64'(bus.out_valid), 64'd0);
        drain();

        // Dword with beat 1 held for three cycles.
        send(64'h0123_4567_89AB_CDEF, 2'b11, 1'b0);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_data", 64'(bus.out_data), 64'h89AB);
            chk("bp_last", 64'(bus.out_last), 64'd0);
            chk("bp_valid", 64'(bus.out_valid), 64'd1);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        drain();

        send(64'h0000_0000_8000_0000, 2'b10, 1'b1);
        send(64'h0000_0000_8000_0000, 2'b10, 1'b0);
        send(64'hFFFF_FFFF_FFFF_8000, 2'b01, 1'b1);
        send(64'h0000_0000_0001_8000, 2'b01, 1'b0);
        drain();

        // Reset for one cycle right after beat 0 of a dword.
        send(64'h0123_4567_89AB_CDEF, 2'b11, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("mid_rst_ovf", 64'(bus.out_ovf), 64'd0);
        chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
        send(64'h1234, 2'b01, 1'b0);
        drain();

        // Random requests under random backpressure.
        rand_bp = 1'b1;
        for (int i = 0; i < 30; i++) begin
            send({$urandom, $urandom} >> $urandom_range(0, 63),
                 2'($urandom), 1'($urandom));
        end
        drain();
        rand_bp = 1'b0;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/store_narrow_serializer.md
# store_narrow_serializer

Store-side counterpart of the datapath sign extender. It accepts a 64-bit register value plus an access size, truncates it to 8/16/32/64 bits, and flags when the truncated value cannot be sign-extended (or zero-extended) back to the original. It then emits the narrowed value little-endian over a narrower memory write bus in one or more beats, using valid/ready on both sides. It sits between the MEM-stage store path and the data-memory write port.

## Interface
- DATA_WIDTH, 64, register/input data width; fixed at 64.
- BUS_WIDTH, 16, memory write bus width; legal values 8, 16, 32, 64.
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  store request present.
- in_ready  out  1  unit can accept a request.
- in_data  in  DATA_WIDTH  register value to store.
- in_size  in  2  access size: 00 byte, 01 half, 10 word, 11 dword.
- in_signed  in  1  1 = overflow check is signed, 0 = unsigned.
- out_valid  out  1  beat present on the write bus.
- out_ready  in  1  memory accepts the current beat.
- out_data  out  BUS_WIDTH  beat data, little-endian order.
- out_be  out  BUS_WIDTH/8  byte enables for out_data.
- out_last  out  1  current beat is the final beat of the request.
- out_ovf  out  1  truncation overflow for the whole request; same value on every beat.

## Operation
- States: IDLE and SEND.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, register the following and go to SEND:
    - in_data.
    - Beat count = max(1, size_bytes/(BUS_WIDTH/8)).
    - Byte-enable pattern.
    - ovf.
- SEND:
  - in_ready=0 and out_valid=1.
  - On out_valid&out_ready with out_last=1, go to IDLE.
  - On out_valid&out_ready with out_last=0:
    - Shift the data register right by BUS_WIDTH.
    - Decrement the beat count.
    - Stay in SEND.
- size_bytes = 1 << in_size. n = 8*size_bytes.
- out_data:
  - Holds the low BUS_WIDTH bits of the data register.
  - When n < BUS_WIDTH, bits above n are driven 0.
- out_be:
  - When n < BUS_WIDTH, the low n/8 bits are 1 and the rest 0.
  - Otherwise all ones on every beat.
- out_last = 1 when the remaining beat count is 1.
- Overflow rules:
  - Signed (in_signed=1): ovf = (in_data != sign-extension of in_data[n-1:0] to 64 bits).
  - Unsigned (in_signed=0): ovf = (in_data[63:n] != 0).
  - dword (in_size=11): ovf = 0.
- Overflow is informational only. Data is always truncated and written.
- Data and control outputs stay stable while out_valid=1 and out_ready=0.
- No beat is skipped or duplicated.

## Timing
- Reset values:
  - State = IDLE.
  - out_valid=0, out_data=0, out_be=0, out_last=0, out_ovf=0.
  - in_ready=0 while reset is high, 1 in the first cycle after reset deasserts.
- Latency: a request accepted at edge t presents beat 0 with out_valid=1 in the cycle after t.
- Each accepted beat advances at the same edge it is accepted. The next beat is visible the following cycle.
- With out_ready held high, a request occupies beats+1 cycles, counting the acceptance cycle.
  - BUS_WIDTH=16: byte/half take 2 cycles, word 3, dword 5.
- No overlap: in_ready stays low through the cycle in which the last beat is accepted. The next request can be accepted the following cycle.
- in_data, in_size and in_signed are sampled only at acceptance. Later changes do not affect an in-flight request.
- Reset mid-transfer:
  - The request is abandoned.
  - Outputs return to their reset values at the next edge.
  - No remaining beats are emitted.
- in_size=11 with BUS_WIDTH=64 gives a single beat with out_be=0xFF.

## Test plan
- Signed byte, no overflow: BUS_WIDTH=16, in_data=0xFFFF_FFFF_FFFF_FF80, size=00, signed=1 -> one beat: out_data=0x0080, out_be=01, out_last=1, out_ovf=0.
- Byte overflow, signed vs unsigned: in_data=0x0000_0000_0000_0080, size=00 -> signed=1 gives out_ovf=1; signed=0 gives out_ovf=0; out_data=0x0080 in both.
- Dword serialization, out_ready=1: in_data=0x0123_4567_89AB_CDEF -> beats 0xCDEF, 0x89AB, 0x4567, 0x0123 on 4 consecutive cycles; out_be=11 each; out_last only on the 4th; in_ready=1 the cycle after.
- Backpressure on the dword above: drop out_ready for 3 cycles while beat 1 is shown -> out_data stays 0x89AB, out_last=0; the sequence resumes with 0x4567 and no beat is lost or repeated.
- Word overflow: in_data=0x0000_0000_8000_0000, size=10 -> beats 0x0000 then 0x8000; out_ovf=1 when signed=1, 0 when signed=0.
- Reset mid-transfer: assert reset for one cycle after beat 0 of a dword -> next cycle out_valid=0, out_ovf=0; in_ready=1 the cycle after reset deasserts; a following half store of 0x1234 emits a single beat 0x1234 with out_last=1.
